// File: rtl/asym_ram_ctrl_pkg.sv
// Shared definitions for the asymmetric-RAM stream controller.
// Contents: integer log2 helper, wide/narrow ratio derivation, pointer-width
// helper, output-buffer depth and the output-buffer occupancy type.
package asym_ram_ctrl_pkg;

    // Ceiling log2 of a positive integer (log2(1) == 0).
    function automatic int log2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    // Number of narrow sub-words per wide word, as a shift amount.
    function automatic int ratio_log2(input int widtha, input int widthb);
        return log2(widtha / widthb);
    endfunction

    // Pointers carry one wrap bit above the RAM address.
    function automatic int ptr_width(input int addr_w);
        return addr_w + 1;
    endfunction

    localparam int OBUF_DEPTH = 3;
    localparam int OBUF_CNT_W = log2(OBUF_DEPTH + 1);

    typedef logic [OBUF_CNT_W-1:0] obuf_cnt_t;

endpackage

// File: rtl/asym_ram_ctrl_obuf.sv
// Small output buffer for narrow words returned by the RAM read port.
// Head is always entry 0; a pop shifts the remaining entries down.
// Ports:
//   clk, rst  clock and synchronous active-high reset (occupancy only)
//   push/din  write one word at the tail
//   pop       drop the head word (ignored when empty)
//   cnt       current occupancy, 0..OBUF_DEPTH
//   head      word at the head (meaningless when cnt == 0)
module asym_ram_ctrl_obuf
    import asym_ram_ctrl_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output obuf_cnt_t    cnt,
    output logic [W-1:0] head
);

    logic [W-1:0] mem [OBUF_DEPTH];
    obuf_cnt_t    cnt_r;
    obuf_cnt_t    wr_idx;
    logic         do_pop;

    assign do_pop = pop && (cnt_r != '0);
    // When popping in the same cycle, the tail slot has already moved down one.
    assign wr_idx = do_pop ? (cnt_r - obuf_cnt_t'(1)) : cnt_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + obuf_cnt_t'(push) - obuf_cnt_t'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_pop) begin
            for (int i = 0; i < OBUF_DEPTH - 1; i++) begin
                mem[i] <= mem[i+1];
            end
        end
        if (push && (wr_idx < obuf_cnt_t'(OBUF_DEPTH))) begin
            mem[wr_idx] <= din;
        end
    end

    assign cnt  = cnt_r;
    assign head = mem[0];

endmodule

// File: rtl/asym_ram_stream_ctrl.sv
// Width-converting FIFO controller around an external asymmetric true-dual-port
// RAM (read-first). Wide words from s_* are written through port A; narrow
// words are read through port B and presented on m_* via a 3-entry buffer.
// Optional build macro: ASYM_CTRL_LEVEL_EN adds the 'level' output.
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   s_valid/s_ready/s_data  wide input stream
//   m_valid/m_ready/m_data  narrow output stream
//   ram_enaA/weA/addrA/diA  RAM port A (write only)
//   ram_enaB/weB/addrB/doB  RAM port B (read only, 1-cycle read latency)
//   level                 stored narrow words (ASYM_CTRL_LEVEL_EN only)
module asym_ram_stream_ctrl
    import asym_ram_ctrl_pkg::*;
#(
    parameter int WIDTHA     = 16,
    parameter int WIDTHB     = 4,
    parameter int SIZEA      = 256,
    parameter int SIZEB      = 1024,
    parameter int ADDRWIDTHA = 8,
    parameter int ADDRWIDTHB = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WIDTHA-1:0]     s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [WIDTHB-1:0]     m_data,
    output logic                  ram_enaA,
    output logic                  ram_weA,
    output logic [ADDRWIDTHA-1:0] ram_addrA,
    output logic [WIDTHA-1:0]     ram_diA,
    output logic                  ram_enaB,
    output logic                  ram_weB,
    output logic [ADDRWIDTHB-1:0] ram_addrB,
    input  logic [WIDTHB-1:0]     ram_doB
`ifdef ASYM_CTRL_LEVEL_EN
    ,
    output logic [ADDRWIDTHB:0]   level
`endif
);

    localparam int RATIO = WIDTHA / WIDTHB;
    localparam int LOG2R = ratio_log2(WIDTHA, WIDTHB);
    localparam int PWA   = ptr_width(ADDRWIDTHA);
    localparam int PWB   = ptr_width(ADDRWIDTHB);
    // Narrow capacity; if the two geometries disagree, trust the smaller one.
    localparam int CAP   = (SIZEA * RATIO < SIZEB) ? SIZEA * RATIO : SIZEB;
    localparam logic [PWB-1:0] FULL_TH = PWB'(CAP - RATIO);

    logic [PWA-1:0] wptr;
    logic [PWB-1:0] rptr;
    logic [PWB-1:0] cnt;
    logic           empty;
    logic           full;
    logic           accept;
    logic           rd;
    logic           pend;
    logic           pop;
    obuf_cnt_t      obuf_cnt;
    logic [2:0]     credit_use;

    // Write pointer scaled to narrow units; the wrap bits make the modular
    // difference unambiguous for both empty and full.
    assign cnt   = (PWB'(wptr) << LOG2R) - rptr;
    assign empty = (cnt == '0);
    assign full  = (cnt > FULL_TH);

    assign s_ready = !full && !rst;
    assign accept  = s_valid && s_ready;

    // Credit check counts the word still in flight from the RAM so the
    // buffer can never be overrun.
    assign credit_use = 3'(obuf_cnt) + 3'(pend);
    assign rd         = !rst && !empty && (credit_use < 3'(OBUF_DEPTH));

    assign ram_enaA  = accept;
    assign ram_weA   = accept;
    assign ram_addrA = wptr[ADDRWIDTHA-1:0];
    assign ram_diA   = s_data;
    assign ram_enaB  = rd;
    assign ram_weB   = 1'b0;
    assign ram_addrB = rptr[ADDRWIDTHB-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            pend <= 1'b0;
        end else begin
            if (accept) wptr <= wptr + PWA'(1);
            if (rd)     rptr <= rptr + PWB'(1);
            pend <= rd;
        end
    end

    assign m_valid = (obuf_cnt != '0);
    assign pop     = m_valid && m_ready;

    // pend is cleared by reset, so a RAM word returning after reset is dropped.
    asym_ram_ctrl_obuf #(
        .W (WIDTHB)
    ) u_obuf (
        .clk  (clk),
        .rst  (rst),
        .push (pend),
        .din  (ram_doB),
        .pop  (pop),
        .cnt  (obuf_cnt),
        .head (m_data)
    );

`ifdef ASYM_CTRL_LEVEL_EN
    assign level = cnt;
`endif

endmodule

// File: tb/tb_asym_ram_stream_ctrl.sv
module tb_asym_ram_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [3:0]  m_data;
    logic        ram_enaA, ram_weA, ram_enaB, ram_weB;
    logic [7:0]  ram_addrA;
    logic [15:0] ram_diA;
    logic [9:0]  ram_addrB;
    logic [3:0]  ram_doB;
`ifdef ASYM_CTRL_LEVEL_EN
    logic [10:0] level;
`endif

    always #5 clk = ~clk;

    asym_ram_stream_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .ram_enaA  (ram_enaA),
        .ram_weA   (ram_weA),
        .ram_addrA (ram_addrA),
        .ram_diA   (ram_diA),
        .ram_enaB  (ram_enaB),
        .ram_weB   (ram_weB),
        .ram_addrB (ram_addrB),
        .ram_doB   (ram_doB)
`ifdef ASYM_CTRL_LEVEL_EN
        ,
        .level     (level)
`endif
    );

    // Behavioural asymmetric read-first RAM: 256 x 16 on A, 1024 x 4 on B.
    logic [3:0] ram [1024];
    always @(posedge clk) begin
        if (ram_enaB && !ram_weB) ram_doB <= ram[ram_addrB];
        if (ram_enaA && ram_weA) begin
            for (int i = 0; i < 4; i++) ram[int'(ram_addrA) * 4 + i] <= ram_diA[i*4 +: 4];
        end
    end

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: expected narrow words in emission order.
    logic [3:0] sbq [$];
    bit         sb_on = 1'b0;
    int         acc_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
        end else begin
            if (s_valid && s_ready) begin
                acc_cnt++;
                if (sb_on) for (int i = 0; i < 4; i++) sbq.push_back(s_data[i*4 +: 4]);
            end
            if (sb_on && m_valid && m_ready) begin
                if (sbq.size() == 0) chk("sb_underflow", 32'(m_data), 32'hDEAD);
                else chk("sb_data", 32'(m_data), 32'(sbq.pop_front()));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        sv;
        logic [15:0] sd;
        logic        mr;
        logic        x_sr;
        logic        x_mv;
        logic [3:0]  x_md;
        logic        x_ea;
        logic        x_eb;
    } vec_t;

    function automatic vec_t mk(logic sv, logic [15:0] sd, logic mr, logic x_sr,
                                logic x_mv, logic [3:0] x_md, logic x_ea, logic x_eb);
        vec_t v;
        v.sv = sv; v.sd = sd; v.mr = mr; v.x_sr = x_sr;
        v.x_mv = x_mv; v.x_md = x_md; v.x_ea = x_ea; v.x_eb = x_eb;
        return v;
    endfunction

    vec_t tbl [20];

    task automatic drain(input string nm);
        int n;
        s_valid = 1'b0;
        m_ready = 1'b1;
        n = 0;
        while ((sbq.size() != 0 || m_valid) && n < 3000) begin
            @(negedge clk);
            cyc();
            n++;
        end
        chk({nm, "_drain_done"}, 32'(n < 3000), 32'd1);
        @(negedge clk);
        chk({nm, "_sb_empty"}, 32'(sbq.size()), 32'd0);
        chk({nm, "_mvalid_idle"}, 32'(m_valid), 32'd0);
        cyc();
    endtask

    initial begin
        int a0, n, gaps, acc_w;
        logic [3:0] exp_n [4];

        // Single word 0xABCD: LS nibble first, m_valid three cycles after accept.
        tbl[0]  = mk(1, 16'hABCD, 1, 1, 0, 4'h0, 1, 0);
        tbl[1]  = mk(0, 16'h0000, 1, 1, 0, 4'h0, 0, 1);
        tbl[2]  = mk(0, 16'h0000, 1, 1, 0, 4'h0, 0, 1);
        tbl[3]  = mk(0, 16'h0000, 1, 1, 1, 4'hD, 0, 1);
        tbl[4]  = mk(0, 16'h0000, 1, 1, 1, 4'hC, 0, 1);
        tbl[5]  = mk(0, 16'h0000, 1, 1, 1, 4'hB, 0, 0);
        tbl[6]  = mk(0, 16'h0000, 1, 1, 1, 4'hA, 0, 0);
        tbl[7]  = mk(0, 16'h0000, 1, 1, 0, 4'h0, 0, 0);
        // Back-to-back 0x1357, 0x2468: eight narrow words with no gap.
        tbl[8]  = mk(1, 16'h1357, 1, 1, 0, 4'h0, 1, 0);
        tbl[9]  = mk(1, 16'h2468, 1, 1, 0, 4'h0, 1, 1);
        tbl[10] = mk(0, 16'h0000, 1, 1, 0, 4'h0, 0, 1);
        tbl[11] = mk(0, 16'h0000, 1, 1, 1, 4'h7, 0, 1);
        tbl[12] = mk(0, 16'h0000, 1, 1, 1, 4'h5, 0, 1);
        tbl[13] = mk(0, 16'h0000, 1, 1, 1, 4'h3, 0, 1);
        tbl[14] = mk(0, 16'h0000, 1, 1, 1, 4'h1, 0, 1);
        tbl[15] = mk(0, 16'h0000, 1, 1, 1, 4'h8, 0, 1);
        tbl[16] = mk(0, 16'h0000, 1, 1, 1, 4'h6, 0, 1);
        tbl[17] = mk(0, 16'h0000, 1, 1, 1, 4'h4, 0, 0);
        tbl[18] = mk(0, 16'h0000, 1, 1, 1, 4'h2, 0, 0);
        tbl[19] = mk(0, 16'h0000, 1, 1, 0, 4'h0, 0, 0);

        // Reset: two cycles with a word offered, nothing may move.
        rst = 1'b1; s_valid = 1'b1; s_data = 16'hFFFF; m_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            @(negedge clk);
            chk("rst_s_ready", 32'(s_ready), 32'd0);
            chk("rst_m_valid", 32'(m_valid), 32'd0);
            chk("rst_enaA", 32'(ram_enaA), 32'd0);
            chk("rst_enaB", 32'(ram_enaB), 32'd0);
        end
        cyc();
        rst = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_s_ready", 32'(s_ready), 32'd1);
        chk("post_rst_weB", 32'(ram_weB), 32'd0);
`ifdef ASYM_CTRL_LEVEL_EN
        chk("post_rst_level", 32'(level), 32'd0);
`endif
        cyc();

        for (int i = 0; i < 20; i++) begin
            s_valid = tbl[i].sv; s_data = tbl[i].sd; m_ready = tbl[i].mr;
            @(negedge clk);
            chk($sformatf("v%0d_s_ready", i), 32'(s_ready), 32'(tbl[i].x_sr));
            chk($sformatf("v%0d_m_valid", i), 32'(m_valid), 32'(tbl[i].x_mv));
            chk($sformatf("v%0d_enaA", i), 32'(ram_enaA), 32'(tbl[i].x_ea));
            chk($sformatf("v%0d_enaB", i), 32'(ram_enaB), 32'(tbl[i].x_eb));
            if (tbl[i].x_mv) chk($sformatf("v%0d_m_data", i), 32'(m_data), 32'(tbl[i].x_md));
            cyc();
        end

        // Full cutoff with the consumer stalled: 3 nibbles sit in the buffer,
        // so 256 words give cnt = 1021 > 1020 and the 257th is refused.
        sb_on = 1'b1;
        m_ready = 1'b0; s_valid = 1'b1;
        a0 = acc_cnt;
        for (int i = 0; i < 300; i++) begin
            s_data = 16'($urandom);
            @(negedge clk);
            cyc();
        end
        @(negedge clk);
        chk("full_accepts", 32'(acc_cnt - a0), 32'd256);
        chk("full_s_ready", 32'(s_ready), 32'd0);
`ifdef ASYM_CTRL_LEVEL_EN
        chk("full_level", 32'(level), 32'd1021);
`endif
        cyc();
        s_valid = 1'b0; m_ready = 1'b1;
        @(negedge clk);
        chk("pop1_m_valid", 32'(m_valid), 32'd1);
        chk("pop1_s_ready", 32'(s_ready), 32'd0);
        cyc();
        m_ready = 1'b0;
        @(negedge clk);
        chk("pop1_next_s_ready", 32'(s_ready), 32'd0);
        chk("pop1_refill_enaB", 32'(ram_enaB), 32'd1);
        cyc();
        @(negedge clk);
        chk("pop1_freed_s_ready", 32'(s_ready), 32'd1);
`ifdef ASYM_CTRL_LEVEL_EN
        chk("pop1_level", 32'(level), 32'd1020);
`endif
        cyc();
        drain("full");

        // Random traffic across many pointer wraps.
        a0 = acc_cnt; n = 0;
        while ((acc_cnt - a0) < 5000 && n < 60000) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = 16'($urandom);
            m_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc();
            n++;
        end
        chk("rand_done", 32'(n < 60000), 32'd1);
        drain("rand");

        // Continuous streaming: after fill, one narrow out per cycle and one
        // wide in every fourth cycle.
        s_valid = 1'b1; m_ready = 1'b1;
        gaps = 0; acc_w = 0;
        for (int i = 0; i < 700; i++) begin
            s_data = 16'($urandom);
            @(negedge clk);
            if (i >= 500) begin
                if (!m_valid) gaps++;
                if (s_ready) acc_w++;
            end
            cyc();
        end
        chk("stream_gaps", 32'(gaps), 32'd0);
        chk("stream_accepts", 32'(acc_w), 32'd50);
        drain("stream");

        // Reset mid-operation with three words stored and a read returning.
        sb_on = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = 16'h1111 * 16'(i + 1);
            @(negedge clk);
            cyc();
        end
        s_valid = 1'b0;
        @(negedge clk);
        chk("mid_read_issued", 32'(ram_enaB), 32'd1);
        cyc();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_enaB", 32'(ram_enaB), 32'd0);
        cyc();
        rst = 1'b0;
        s_valid = 1'b1; s_data = 16'h1234; m_ready = 1'b1;
        @(negedge clk);
        chk("mid_post_m_valid", 32'(m_valid), 32'd0);
        chk("mid_post_s_ready", 32'(s_ready), 32'd1);
`ifdef ASYM_CTRL_LEVEL_EN
        chk("mid_post_level", 32'(level), 32'd0);
`endif
        cyc();
        s_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("mid_lat_m_valid", 32'(m_valid), 32'd0);
            cyc();
        end
        exp_n[0] = 4'h4; exp_n[1] = 4'h3; exp_n[2] = 4'h2; exp_n[3] = 4'h1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_word_m_valid", 32'(m_valid), 32'd1);
            chk("mid_word_m_data", 32'(m_data), 32'(exp_n[i]));
            cyc();
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_tail_m_valid", 32'(m_valid), 32'd0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
